// File: rtl/lopd_norm_pkg.sv
// Shared types and constants for the leading-one detect / normalize arbiter.
// Optional macro LOPD_NORM_FIXED_PRIO_EN (see lopd_norm_arbiter) needs nothing here.
package lopd_norm_pkg;

    localparam int LOPD_NORM_DATA_W = 16;
    localparam int LOPD_NORM_POS_W  = 4;

    typedef logic [0:0] req_id_t;

    typedef struct packed {
        logic [LOPD_NORM_DATA_W-1:0] mant;
        logic [LOPD_NORM_POS_W-1:0]  shift;
        logic                        zero;
        req_id_t                     id;
    } norm_result_t;

endpackage

// File: rtl/lopd_norm_shift.sv
// Combinational leading-one detector plus barrel left shift that moves the
// leading one to the MSB; a zero operand yields shift 0 and mantissa 0.
module lopd_norm_shift
    import lopd_norm_pkg::*;
#(
    parameter int DATA_W = LOPD_NORM_DATA_W,
    parameter int POS_W  = $clog2(DATA_W)
) (
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_mant,
    output logic [POS_W-1:0]  o_shift,
    output logic              o_zero
);

    logic [POS_W-1:0] pos;

    always_comb begin
        pos    = '0;
        o_zero = (i_data == '0);
        // Scanning upward lets the highest set bit overwrite lower ones.
        for (int i = 0; i < DATA_W; i++) begin
            if (i_data[i]) begin
                pos = POS_W'(i);
            end
        end
        o_shift = o_zero ? '0 : (POS_W'(DATA_W - 1) - pos);
        o_mant  = i_data << o_shift;
    end

endmodule

// File: rtl/lopd_norm_arbiter.sv
// Two-requester arbiter feeding a shared leading-one normalizer (2-stage pipe).
// Define LOPD_NORM_FIXED_PRIO_EN for fixed priority (requester 0 wins) instead of round-robin.
module lopd_norm_arbiter
    import lopd_norm_pkg::*;
#(
    parameter int DATA_W = LOPD_NORM_DATA_W,
    parameter int POS_W  = $clog2(DATA_W)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req0_valid,
    input  logic [DATA_W-1:0] i_req0_data,
    output logic              o_req0_ready,
    input  logic              i_req1_valid,
    input  logic [DATA_W-1:0] i_req1_data,
    output logic              o_req1_ready,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_mant,
    output logic [POS_W-1:0]  o_shift,
    output logic              o_zero_flag,
    output logic              o_id
);

    logic              a_valid_q, a_valid_d;
    logic [DATA_W-1:0] a_data_q, a_data_d;
    req_id_t           a_id_q, a_id_d;
    logic              o_valid_q, o_valid_d;
    logic [DATA_W-1:0] mant_q, mant_d;
    logic [POS_W-1:0]  shift_q, shift_d;
    logic              zero_q, zero_d;
    req_id_t           id_q, id_d;
`ifndef LOPD_NORM_FIXED_PRIO_EN
    req_id_t           ptr_q, ptr_d;
`endif

    logic [1:0]        grant;
    logic              s_a_ready;
    logic              s_b_ready;
    logic              accept;
    logic [DATA_W-1:0] n_mant;
    logic [POS_W-1:0]  n_shift;
    logic              n_zero;

    lopd_norm_shift #(
        .DATA_W (DATA_W),
        .POS_W  (POS_W)
    ) u_shift (
        .i_data  (a_data_q),
        .o_mant  (n_mant),
        .o_shift (n_shift),
        .o_zero  (n_zero)
    );

    always_comb begin
        grant = 2'b00;
`ifdef LOPD_NORM_FIXED_PRIO_EN
        if (i_req0_valid) begin
            grant = 2'b01;
        end else if (i_req1_valid) begin
            grant = 2'b10;
        end
`else
        // On contention the requester that did not win last time goes next.
        if (i_req0_valid && i_req1_valid) begin
            grant = (ptr_q == 1'b1) ? 2'b01 : 2'b10;
        end else begin
            grant = {i_req1_valid, i_req0_valid};
        end
`endif
    end

    assign s_b_ready    = ~o_valid_q | i_ready;
    assign s_a_ready    = ~a_valid_q | s_b_ready;
    assign accept       = (|grant) & s_a_ready;
    assign o_req0_ready = grant[0] & s_a_ready;
    assign o_req1_ready = grant[1] & s_a_ready;

    always_comb begin
        a_valid_d = a_valid_q;
        a_data_d  = a_data_q;
        a_id_d    = a_id_q;
        o_valid_d = o_valid_q;
        mant_d    = mant_q;
        shift_d   = shift_q;
        zero_d    = zero_q;
        id_d      = id_q;
`ifndef LOPD_NORM_FIXED_PRIO_EN
        ptr_d     = ptr_q;
`endif
        if (s_a_ready) begin
            a_valid_d = accept;
        end
        if (accept) begin
            a_data_d = grant[1] ? i_req1_data : i_req0_data;
            a_id_d   = req_id_t'(grant[1]);
`ifndef LOPD_NORM_FIXED_PRIO_EN
            ptr_d    = req_id_t'(grant[1]);
`endif
        end
        if (s_b_ready) begin
            o_valid_d = a_valid_q;
            if (a_valid_q) begin
                mant_d  = n_mant;
                shift_d = n_shift;
                zero_d  = n_zero;
                id_d    = a_id_q;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_valid_q <= 1'b0;
            a_data_q  <= '0;
            a_id_q    <= '0;
            o_valid_q <= 1'b0;
            mant_q    <= '0;
            shift_q   <= '0;
            zero_q    <= 1'b0;
            id_q      <= '0;
`ifndef LOPD_NORM_FIXED_PRIO_EN
            ptr_q     <= 1'b1;
`endif
        end else begin
            a_valid_q <= a_valid_d;
            a_data_q  <= a_data_d;
            a_id_q    <= a_id_d;
            o_valid_q <= o_valid_d;
            mant_q    <= mant_d;
            shift_q   <= shift_d;
            zero_q    <= zero_d;
            id_q      <= id_d;
`ifndef LOPD_NORM_FIXED_PRIO_EN
            ptr_q     <= ptr_d;
`endif
        end
    end

    assign o_valid     = o_valid_q;
    assign o_mant      = mant_q;
    assign o_shift     = shift_q;
    assign o_zero_flag = zero_q;
    assign o_id        = id_q;

endmodule
